// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath controller and the memory responder.
// The controller owns the request side, the responder owns data return and status.
interface mem_responder_if;
   logic        in_init;
   logic        mr;
   logic        mw;
   logic [31:0] ao;
   logic [31:0] do_in;
   logic [31:0] di;
   logic        ack;
   logic        busy;
   logic        err;

   modport master (
      output in_init, mr, mw, ao, do_in,
      input  di, ack, busy, err
   );

   modport slave (
      input  in_init, mr, mw, ao, do_in,
      output di, ack, busy, err
   );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory with a fixed number of wait states per access.
// Requests are latched on acceptance and complete with a one-cycle ack pulse.
module mem_responder #(
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned DEPTH_LOG2  = 10
) (
   input logic            clk,
   input logic            reset,
   mem_responder_if.slave bus
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      ACK
   } state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [31:0]             di_q, di_d;
   logic                    rd_q, rd_d;
   logic                    fault_q, fault_d;
   logic                    mem_we;
   logic                    req_bad;

   logic [31:0] mem_q [DEPTH];

   // An address beyond the array or an ambiguous/empty opcode is rejected, not wrapped.
   assign req_bad = (bus.mr == bus.mw) || ((bus.ao >> DEPTH_LOG2) != '0);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      di_d    = di_q;
      rd_d    = rd_q;
      fault_d = fault_q;
      mem_we  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.in_init) begin
               addr_d  = bus.ao[DEPTH_LOG2-1:0];
               wdata_d = bus.do_in;
               rd_d    = bus.mr;
               fault_d = req_bad;
               if (WAIT_STATES == 0) begin
                  state_d = ACCESS;
                  cnt_d   = '0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = ACK;
            if (!fault_q) begin
               if (rd_q) begin
                  di_d = mem_q[addr_q];
               end else begin
                  mem_we = 1'b1;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         di_q    <= '0;
         rd_q    <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         di_q    <= di_d;
         rd_q    <= rd_d;
         fault_q <= fault_d;
      end
   end

   // NOTE: the array has no reset so it maps onto RAM and keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   // Status flags decode straight from state, so reset clears them at once.
   assign bus.ack  = (state_q == ACK);
   assign bus.busy = (state_q != IDLE);
   assign bus.err  = (state_q == ACK) && fault_q;
   assign bus.di   = di_q;

endmodule
